// File: rtl/fft_out_framer_pkg.sv
// Shared types and constants for the FFT output framer: sample width,
// entry tag layout and the ldn -> block size decode.
package fft_out_framer_pkg;

    localparam int FFT_OUT_WIDTH = 16;
    localparam int IDX_W         = 11;
    localparam int N_W           = 12;
    localparam int TAG_W         = IDX_W + 2;

    typedef enum logic {
        IDLE     = 1'b0,
        IN_BLOCK = 1'b1
    } frm_state_t;

    typedef struct packed {
        logic             sop;
        logic             eop;
        logic [IDX_W-1:0] idx;
    } tag_t;

    // Sizes 4..2048 come from ldn 2..11; anything else selects the largest block.
    function automatic logic [N_W-1:0] ldn_to_n(input logic [3:0] ldn);
        logic [N_W-1:0] n;
        if (ldn >= 4'd2 && ldn <= 4'd11) n = N_W'(1) << ldn;
        else                             n = N_W'(2048);
        return n;
    endfunction

endpackage

// File: rtl/fft_out_framer_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers. It also exposes the entry that
// will be at the head after this cycle's pop, so the caller can register it.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk_sys,
    input  logic             rst_sys,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic             full,
    output logic             nxt_vld,
    output logic [WIDTH-1:0] nxt_data
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr, rd_ptr_nxt;
    logic             empty, do_wr, do_rd;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]});
    assign do_rd = rd_en && !empty;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign do_wr = wr_en && (!full || do_rd);

    assign rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, do_rd};
    // Compared against the pre-write pointer: an entry written this cycle
    // only becomes visible one cycle later.
    assign nxt_vld    = (rd_ptr_nxt != wr_ptr);
    assign nxt_data   = mem[rd_ptr_nxt[AW-1:0]];

    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            rd_ptr <= rd_ptr_nxt;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/fft_out_framer.sv
// Frames bit-reversed FFT samples into blocks (sop/eop/idx), buffers them in
// a FIFO and presents them on a registered valid/ready output.
module fft_out_framer
    import fft_out_framer_pkg::*;
#(
    parameter int DW    = FFT_OUT_WIDTH,
    parameter int DEPTH = 16
) (
    input  logic                 clk_sys,
    input  logic                 rst_sys,
    input  logic                 block_sync_i,
    input  logic                 data_val_i,
    input  logic signed [DW-1:0] data_real_i,
    input  logic signed [DW-1:0] data_imag_i,
    input  logic [3:0]           ldn_rg_i,
    input  logic                 data_ready_i,
    output logic                 data_val_o,
    output logic signed [DW-1:0] data_real_o,
    output logic signed [DW-1:0] data_imag_o,
    output logic                 sop_o,
    output logic                 eop_o,
    output logic [IDX_W-1:0]     idx_o,
    output logic                 overflow_o,
    output logic                 err_short_o,
    output logic                 orphan_o
);
    localparam int EW = TAG_W + 2*DW;

    frm_state_t       state_q, state_d;
    logic [N_W-1:0]   n_q;
    logic [IDX_W-1:0] idx_q;
    logic             last_smp;
    tag_t             acc_tag, out_tag;
    logic             acc_wr, acc_err, acc_orphan;
    logic             in_vld;
    logic [EW-1:0]    in_entry, nxt_data;
    logic             fifo_full, nxt_vld, pop;

    assign last_smp = ({1'b0, idx_q} == n_q - N_W'(1));

    always_ff @(posedge clk_sys) begin
        if (rst_sys) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (data_val_i && block_sync_i) state_d = IN_BLOCK;
            IN_BLOCK: if (data_val_i && !block_sync_i && last_smp) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        acc_wr     = 1'b0;
        acc_err    = 1'b0;
        acc_orphan = 1'b0;
        acc_tag    = '{sop: 1'b0, eop: 1'b0, idx: idx_q};
        if (data_val_i) begin
            if (block_sync_i) begin
                acc_wr      = 1'b1;
                acc_tag.sop = 1'b1;
                acc_tag.idx = '0;
                acc_err     = (state_q == IN_BLOCK);
            end else if (state_q == IN_BLOCK) begin
                acc_wr      = 1'b1;
                acc_tag.eop = last_smp;
            end else begin
                acc_orphan  = 1'b1;
            end
        end
    end

    // idx tracks accepted samples, independent of whether the FIFO keeps them.
    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            n_q   <= N_W'(2048);
            idx_q <= '0;
        end else if (data_val_i && block_sync_i) begin
            n_q   <= ldn_to_n(ldn_rg_i);
            idx_q <= IDX_W'(1);
        end else if (acc_wr) begin
            idx_q <= acc_tag.eop ? '0 : idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            in_vld      <= 1'b0;
            in_entry    <= '0;
            err_short_o <= 1'b0;
            orphan_o    <= 1'b0;
        end else begin
            in_vld      <= acc_wr;
            in_entry    <= {acc_tag, data_real_i, data_imag_i};
            err_short_o <= acc_err;
            orphan_o    <= acc_orphan;
        end
    end

    assign pop = data_val_o && data_ready_i;

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_sys  (clk_sys),
        .rst_sys  (rst_sys),
        .wr_en    (in_vld),
        .wr_data  (in_entry),
        .rd_en    (pop),
        .full     (fifo_full),
        .nxt_vld  (nxt_vld),
        .nxt_data (nxt_data)
    );

    always_ff @(posedge clk_sys) begin
        if (rst_sys)                           overflow_o <= 1'b0;
        else if (in_vld && fifo_full && !pop)  overflow_o <= 1'b1;
    end

    // The output register mirrors the head; it only advances on a handshake.
    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            data_val_o                           <= 1'b0;
            {out_tag, data_real_o, data_imag_o}  <= '0;
        end else begin
            data_val_o                           <= nxt_vld;
            {out_tag, data_real_o, data_imag_o}  <= nxt_vld ? nxt_data : '0;
        end
    end

    assign sop_o = out_tag.sop;
    assign eop_o = out_tag.eop;
    assign idx_o = out_tag.idx;

endmodule

// File: tb/tb_fft_out_framer.sv
// Self-checking bench for fft_out_framer: a table-driven single block, hand
// sequences for stall/overflow/short/orphan/reset and a randomized 2048 block.
module tb_fft_out_framer;
    localparam int DW = 16;

    typedef struct packed {
        logic          sop;
        logic          eop;
        logic [10:0]   idx;
        logic [DW-1:0] re;
        logic [DW-1:0] im;
    } ent_t;

    typedef struct {
        bit            v;
        bit            s;
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        bit            x_val;
        ent_t          x;
    } vec_t;

    logic                 clk_sys = 1'b0;
    logic                 rst_sys, block_sync_i, data_val_i, data_ready_i;
    logic [3:0]           ldn_rg_i;
    logic signed [DW-1:0] data_real_i, data_imag_i;

    logic                 data_val_o, sop_o, eop_o, overflow_o, err_short_o, orphan_o;
    logic signed [DW-1:0] data_real_o, data_imag_o;
    logic [10:0]          idx_o;
    logic                 val4, sop4, eop4, ovf4, err4, orph4;
    logic signed [DW-1:0] re4, im4;
    logic [10:0]          idx4;

    always #5 clk_sys = ~clk_sys;

    fft_out_framer #(.DW(DW), .DEPTH(16)) u_dut (
        .clk_sys(clk_sys), .rst_sys(rst_sys), .block_sync_i(block_sync_i),
        .data_val_i(data_val_i), .data_real_i(data_real_i), .data_imag_i(data_imag_i),
        .ldn_rg_i(ldn_rg_i), .data_ready_i(data_ready_i), .data_val_o(data_val_o),
        .data_real_o(data_real_o), .data_imag_o(data_imag_o), .sop_o(sop_o),
        .eop_o(eop_o), .idx_o(idx_o), .overflow_o(overflow_o),
        .err_short_o(err_short_o), .orphan_o(orphan_o));

    fft_out_framer #(.DW(DW), .DEPTH(4)) u_dut4 (
        .clk_sys(clk_sys), .rst_sys(rst_sys), .block_sync_i(block_sync_i),
        .data_val_i(data_val_i), .data_real_i(data_real_i), .data_imag_i(data_imag_i),
        .ldn_rg_i(ldn_rg_i), .data_ready_i(data_ready_i), .data_val_o(val4),
        .data_real_o(re4), .data_imag_o(im4), .sop_o(sop4),
        .eop_o(eop4), .idx_o(idx4), .overflow_o(ovf4),
        .err_short_o(err4), .orphan_o(orph4));

    int   n_tot, n_bad;
    ent_t exp_q[$];
    bit   m_in_blk;
    int   m_pos, m_n;
    int   n_pop, n_sop, n_eop, n_err, mono_bad, last_idx;
    vec_t tbl[12];

    function automatic ent_t out16();
        ent_t r;
        r.sop = sop_o; r.eop = eop_o; r.idx = idx_o;
        r.re  = data_real_o; r.im = data_imag_o;
        return r;
    endfunction

    function automatic ent_t out4();
        ent_t r;
        r.sop = sop4; r.eop = eop4; r.idx = idx4;
        r.re  = re4; r.im = im4;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference framing: blocks of 2**ldn samples started by sync.
    task automatic model_acc(input bit v, input bit s, input logic [3:0] ldn,
                             input logic [DW-1:0] re, input logic [DW-1:0] im,
                             output bit e_err, output bit e_orph);
        ent_t e;
        e_err = 0; e_orph = 0;
        e.re = re; e.im = im; e.sop = 0; e.eop = 0; e.idx = '0;
        if (v) begin
            if (s) begin
                e_err    = m_in_blk;
                m_n      = (ldn >= 2 && ldn <= 11) ? (1 << ldn) : 2048;
                e.sop    = 1;
                exp_q.push_back(e);
                m_pos    = 1;
                m_in_blk = 1;
            end else if (m_in_blk) begin
                e.idx = 11'(m_pos);
                e.eop = (m_pos == m_n - 1);
                exp_q.push_back(e);
                if (e.eop) m_in_blk = 0;
                m_pos++;
            end else begin
                e_orph = 1;
            end
        end
    endtask

    task automatic cyc(input bit v, input bit s, input logic [3:0] ldn, input bit rdy);
        ent_t h, e;
        bit   e_err, e_orph;
        logic [DW-1:0] re, im;
        data_ready_i = rdy;
        if (data_val_o && rdy) begin
            h = out16();
            if (exp_q.size() == 0) begin
                n_tot++; n_bad++;
                $display("FAIL pop_extra: got %0h want none", h);
            end else begin
                e = exp_q.pop_front();
                chk("pop_data", 64'(h), 64'(e));
            end
            if (h.sop) n_sop++;
            if (h.eop) n_eop++;
            if (!h.sop && int'(h.idx) != last_idx + 1) mono_bad++;
            last_idx = int'(h.idx);
            n_pop++;
        end
        re = DW'($urandom);
        im = DW'($urandom);
        data_val_i = v; block_sync_i = s; ldn_rg_i = ldn;
        data_real_i = re; data_imag_i = im;
        model_acc(v, s, ldn, re, im, e_err, e_orph);
        @(negedge clk_sys);
        chk("err_short", 64'(err_short_o), 64'(e_err));
        chk("orphan", 64'(orphan_o), 64'(e_orph));
        if (err_short_o) n_err++;
    endtask

    task automatic do_reset();
        rst_sys = 1; data_val_i = 0; block_sync_i = 0; data_ready_i = 0;
        repeat (2) @(negedge clk_sys);
        chk("rst_val", 64'(data_val_o), 64'(0));
        chk("rst_ovf", 64'(overflow_o), 64'(0));
        chk("rst_ovf4", 64'(ovf4), 64'(0));
        chk("rst_out", 64'(out16()), 64'(0));
        chk("rst_pulse", 64'({err_short_o, orphan_o}), 64'(0));
        rst_sys = 0;
        exp_q.delete();
        m_in_blk = 0; m_pos = 0; m_n = 2048;
        n_pop = 0; n_sop = 0; n_eop = 0; n_err = 0; mono_bad = 0; last_idx = -1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ent_t keep[4];
        int   n4, sent;
        bit   go;

        // One 8-sample block, ready held high: outputs trail inputs by two edges.
        for (int k = 0; k < 12; k++) begin
            tbl[k].v  = (k < 8);
            tbl[k].s  = (k == 0);
            tbl[k].re = DW'(100 + 37 * k);
            tbl[k].im = DW'(-5 * k);
            tbl[k].x  = '0;
            tbl[k].x_val = (k >= 2 && k < 10);
        end
        for (int k = 2; k < 10; k++) begin
            tbl[k].x.sop = (k == 2);
            tbl[k].x.eop = (k == 9);
            tbl[k].x.idx = 11'(k - 2);
            tbl[k].x.re  = tbl[k-2].re;
            tbl[k].x.im  = tbl[k-2].im;
        end

        rst_sys = 1; data_val_i = 0; block_sync_i = 0; data_ready_i = 0;
        ldn_rg_i = 0; data_real_i = 0; data_imag_i = 0;
        do_reset();

        data_ready_i = 1; ldn_rg_i = 4'd3;
        for (int k = 0; k < 12; k++) begin
            data_val_i = tbl[k].v; block_sync_i = tbl[k].s;
            data_real_i = tbl[k].re; data_imag_i = tbl[k].im;
            @(negedge clk_sys);
            chk("tbl_val", 64'(data_val_o), 64'(tbl[k].x_val));
            if (tbl[k].x_val) chk("tbl_ent", 64'(out16()), 64'(tbl[k].x));
        end

        // Three 4-sample blocks against a stalled output, then drain.
        do_reset();
        for (int i = 0; i < 12; i++) cyc(1, (i % 4) == 0, 4'd2, 0);
        repeat (8) cyc(0, 0, 4'd2, 0);
        chk("stall_val", 64'(data_val_o), 64'(1));
        chk("stall_head", 64'(out16()), 64'(exp_q[0]));
        chk("stall_ovf", 64'(overflow_o), 64'(0));
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) cyc(0, 0, 4'd2, 1);
        cyc(0, 0, 4'd2, 1);
        chk("drain_left", 64'(exp_q.size()), 64'(0));
        chk("drain_cnt", 64'(n_pop), 64'(12));
        chk("drain_idle", 64'(data_val_o), 64'(0));

        // DEPTH=4 instance: six writes against a stall, the fifth overflows.
        do_reset();
        for (int j = 1; j <= 8; j++) begin
            cyc(j <= 6, j == 1, 4'd3, 0);
            chk("ovf4_step", 64'(ovf4), 64'(j >= 6));
        end
        for (int i = 0; i < 4; i++) keep[i] = exp_q[i];
        n4 = 0;
        for (int i = 0; i < 12; i++) begin
            if (val4) begin
                if (n4 < 4) chk("ovf4_data", 64'(out4()), 64'(keep[n4]));
                else begin
                    n_tot++; n_bad++;
                    $display("FAIL ovf4_extra: got %0h want none", out4());
                end
                n4++;
            end
            cyc(0, 0, 4'd3, 1);
        end
        chk("ovf4_cnt", 64'(n4), 64'(4));
        chk("ovf4_sticky", 64'(ovf4), 64'(1));

        // Short block: resync after 10 of 16 samples.
        do_reset();
        for (int i = 0; i < 10; i++) cyc(1, i == 0, 4'd4, 1);
        for (int i = 0; i < 16; i++) cyc(1, i == 0, 4'd4, 1);
        repeat (6) cyc(0, 0, 4'd4, 1);
        chk("short_err_cnt", 64'(n_err), 64'(1));
        chk("short_pop_cnt", 64'(n_pop), 64'(26));
        chk("short_eop_cnt", 64'(n_eop), 64'(1));
        chk("short_left", 64'(exp_q.size()), 64'(0));

        // Orphan after reset, then reset in the middle of a queued block.
        do_reset();
        cyc(1, 0, 4'd3, 1);
        repeat (4) cyc(0, 0, 4'd3, 1);
        chk("orphan_noout", 64'(n_pop), 64'(0));
        chk("orphan_val", 64'(data_val_o), 64'(0));
        cyc(1, 1, 4'd3, 0);
        repeat (4) cyc(1, 0, 4'd3, 0);
        repeat (3) cyc(0, 0, 4'd3, 0);
        chk("mid_queued", 64'(data_val_o), 64'(1));
        chk("mid_ovf4_pre", 64'(ovf4), 64'(1));
        rst_sys = 1; data_val_i = 0; block_sync_i = 0;
        @(negedge clk_sys);
        chk("mid_rst_val", 64'(data_val_o), 64'(0));
        chk("mid_rst_ovf", 64'(overflow_o), 64'(0));
        chk("mid_rst_ovf4", 64'(ovf4), 64'(0));
        do_reset();
        cyc(1, 0, 4'd3, 1);
        repeat (4) cyc(1, 0, 4'd3, 1);
        repeat (3) cyc(0, 0, 4'd3, 1);
        chk("post_rst_noout", 64'(n_pop), 64'(0));
        chk("post_rst_val", 64'(data_val_o), 64'(0));

        // Full 2048-sample block with random ready and throttled input.
        do_reset();
        sent = 0;
        for (int c = 0; c < 20000 && n_pop < 2048; c++) begin
            go = (sent < 2048) && (exp_q.size() < 12) && ($urandom_range(0, 1) == 1);
            cyc(go, go && sent == 0, 4'd11, $urandom_range(0, 3) != 0);
            if (go) sent++;
        end
        chk("big_pop_cnt", 64'(n_pop), 64'(2048));
        chk("big_sop_cnt", 64'(n_sop), 64'(1));
        chk("big_eop_cnt", 64'(n_eop), 64'(1));
        chk("big_mono", 64'(mono_bad), 64'(0));
        chk("big_last_idx", 64'(last_idx), 64'(2047));
        chk("big_ovf", 64'(overflow_o), 64'(0));

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule

// File: doc/fft_out_framer.md
FFT_OUT_FRAMER -- requirements
Module: fft_out_framer

Interface
REQ-001 SHALL have parameter DW, default `FFT_OUT_WIDTH, meaning the width of each real and imaginary sample.
REQ-002 SHALL have parameter DEPTH, default 16, meaning the number of FIFO entries; it is a power of two, minimum 4.
REQ-003 SHALL have port clk_sys  in  1  single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_sys  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port block_sync_i  in  1  first sample of a block, from the bit-reverse stage.
REQ-006 SHALL have port data_val_i  in  1  input sample valid.
REQ-007 SHALL have ports data_real_i / data_imag_i  in  DW signed each  input sample.
REQ-008 SHALL have port ldn_rg_i  in  4  log2 of the FFT size.
REQ-009 SHALL have port data_ready_i  in  1  downstream ready.
REQ-010 SHALL have port data_val_o  out  1  output sample valid.
REQ-011 SHALL have ports data_real_o / data_imag_o  out  DW signed each  output sample.
REQ-012 SHALL have ports sop_o / eop_o  out  1 each  start / end of block, qualified by data_val_o.
REQ-013 SHALL have port idx_o  out  11  index of the sample within its block.
REQ-014 SHALL have ports overflow_o (sticky), err_short_o (1-cycle pulse), orphan_o (1-cycle pulse)  out  1 each.

Function
REQ-015 SHALL decode N from ldn_rg_i (2..11 -> 4..2048; any other value -> 2048), latched only on an accepted sample with block_sync_i=1.
REQ-016 SHALL treat an input sample as accepted when data_val_i=1; block_sync_i without data_val_i is ignored.
REQ-017 SHALL, on an accepted sample with block_sync_i=1, enter state IN_BLOCK, set idx=0 and tag the entry sop=1.
REQ-018 SHALL, in IN_BLOCK, increment idx by 1 per accepted sample and tag the entry eop=1 when idx==N-1, then go to IDLE.
REQ-019 SHALL, on block_sync_i=1 in IN_BLOCK before eop, pulse err_short_o and restart the block at idx=0; the truncated block carries no eop.
REQ-020 SHALL, in IDLE, drop an accepted sample without block_sync_i and pulse orphan_o.
REQ-021 SHALL write {sop, eop, idx, real, imag} into the FIFO one cycle after acceptance, through an input register stage.
REQ-022 SHALL present the FIFO head on the outputs through an output register; minimum latency from input acceptance to data_val_o is 2 cycles, with no empty-FIFO bypass.
REQ-023 SHALL keep all outputs stable while data_val_o=1 and data_ready_i=0; the head is popped only when data_val_o & data_ready_i.
REQ-024 SHALL, on a write to a full FIFO with no pop in the same cycle, drop the sample and set overflow_o until reset.
REQ-025 SHALL accept a simultaneous write and pop when full, with no overflow.
REQ-026 SHALL wrap the read/write pointers modulo DEPTH; full/empty are derived from an extra pointer MSB.
REQ-027 SHALL leave a dropped sample's effect on idx unchanged; idx counts accepted samples, not written ones.

Reset
REQ-028 SHALL, while rst_sys=1, clear the FIFO pointers, set state IDLE, idx=0 and N=2048.
REQ-029 SHALL, while rst_sys=1, drive all outputs to 0, including overflow_o.
REQ-030 SHALL discard a block that is in flight when reset is asserted; after release, only a new block_sync_i starts framing.

Structure
REQ-031 SHALL take DW from fixed_point.v; the ldn->N decode and the entry field widths (sop/eop/idx) belong in the shared macros.v.
REQ-032 SHALL place the FIFO storage, pointers and full/empty logic in one sub-module, sync_fifo (parameters WIDTH, DEPTH).
REQ-033 SHALL implement the framer state machine (IDLE, IN_BLOCK), the counters and the error flags in the top level.

Verification
REQ-034 SHALL cover: ldn=3, 8 contiguous samples with sync on the first, data_ready_i=1 -> 8 outputs at idx 0..7, sop on idx 0, eop on idx 7, first output 2 cycles after the first input.
REQ-035 SHALL cover: ldn=2, data_ready_i=0 for 20 cycles while 3 blocks (12 samples) arrive, DEPTH=16 -> no overflow; after release, 12 samples come out in order with values preserved.
REQ-036 SHALL cover: DEPTH=4, data_ready_i=0, 6 samples -> first 4 kept, overflow_o=1 from the 5th write onward, and it stays set.
REQ-037 SHALL cover: ldn=4, sync again after 10 samples -> err_short_o one pulse, the new block's idx restarts at 0, and no eop in the first block.
REQ-038 SHALL cover: valid without sync after reset -> orphan_o pulse and no output; then reset asserted mid-block with 5 entries queued -> data_val_o=0 and overflow_o=0 the next cycle.
REQ-039 SHALL cover: ldn=11 full block with random data_ready_i -> 2048 outputs, idx 0..2047 monotonic, and exactly one sop and one eop.
